sound_sequencer: RTL and testbench

- Note scheduler that feeds the buzzer tone generator (`sound`) from a CPU-written note queue.
- CPU pushes (period, duration) pairs into an internal FIFO.
- The sequencer pops each note, drives `max_count` and a one-cycle `latch_max_count` into `sound`, and holds the note for its duration in milliseconds.
- When the queue drains, it latches silence (`max_count = 0`).

---
 rtl/sound_sequencer_if.sv | 29 ++
 rtl/sound_sequencer.sv | 212 +++++++++++++++++++++
 tb/tb_sound_sequencer.sv | 295 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sound_sequencer_if.sv
// Note-queue bus between the CPU side and sound_sequencer, plus the tone
// outputs that feed the buzzer generator.
interface sound_sequencer_if #(
    parameter int DEPTH = 8
);
    logic [25:0]              note_period;
    logic [15:0]              note_duration_ms;
    logic                     note_push;
    logic                     stop;
    logic                     fifo_full;
    logic [$clog2(DEPTH):0]   fifo_count;
    logic                     overflow;
    logic                     busy;
    logic                     note_done;
    logic [25:0]              max_count;
    logic                     latch_max_count;

    modport master (
        output note_period, note_duration_ms, note_push, stop,
        input  fifo_full, fifo_count, overflow, busy, note_done,
               max_count, latch_max_count
    );

    modport slave (
        input  note_period, note_duration_ms, note_push, stop,
        output fifo_full, fifo_count, overflow, busy, note_done,
               max_count, latch_max_count
    );
endinterface

// File: rtl/sound_sequencer.sv
// Note scheduler: queues (period, duration) pairs and latches each period into
// the tone generator for its duration. Optional inter-note gap: SOUND_SEQ_GAP_EN.
module sound_sequencer #(
    parameter int DEPTH       = 8,
    parameter int CLKS_PER_MS = 50000,
    parameter int GAP_MS      = 10
) (
    input  logic              clk,
    input  logic              rst_async,
    sound_sequencer_if.slave  bus
);
    localparam int AW    = $clog2(DEPTH);
    localparam int CW    = AW + 1;
    localparam int PRE_W = (CLKS_PER_MS > 1) ? $clog2(CLKS_PER_MS) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(CLKS_PER_MS - 1);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || CLKS_PER_MS < 1 || GAP_MS < 0) begin : g_bad_params
        $error("sound_sequencer: invalid parameters");
    end

`ifdef SOUND_SEQ_GAP_EN
    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_PLAY, S_SILENCE, S_GAP} state_t;
`else
    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_PLAY, S_SILENCE} state_t;
`endif

    state_t            r_state, w_state_nxt;
    logic [25:0]       r_mem_per [DEPTH];
    logic [15:0]       r_mem_dur [DEPTH];
    logic [AW-1:0]     r_wr_ptr, r_rd_ptr;
    logic [CW-1:0]     r_count, w_count_nxt;
    logic              r_full, r_overflow;
    logic [PRE_W-1:0]  r_pre, w_pre_nxt;
    logic [15:0]       r_ms, w_ms_nxt;
    logic [15:0]       r_dur;
    logic [25:0]       r_max_count;
    logic              r_latch, r_note_done, r_busy;
    logic              w_empty, w_push_ok, w_pop, w_flush, w_take;
    logic              w_ld_note, w_ld_sil, w_last, w_done_nxt;
    logic [25:0]       w_head_per;
    logic [15:0]       w_head_dur;

    assign w_empty    = (r_count == '0);
    assign w_head_per = r_mem_per[r_rd_ptr];
    assign w_head_dur = r_mem_dur[r_rd_ptr];
    assign w_push_ok  = bus.note_push && !r_full && !bus.stop;
    assign w_last     = (r_pre == PRE_LAST) && (r_ms == r_dur - 16'd1);

`ifdef SOUND_SEQ_GAP_EN
    localparam int GAP_CYC = GAP_MS * CLKS_PER_MS;
    localparam int GW      = $clog2(GAP_CYC + 1);
    logic [GW-1:0] r_gap;
    logic          w_gap_done;

    // The zero latch lands in the last PLAY cycle, so GAP itself lasts one
    // cycle less than the silent span that precedes the next latch.
    assign w_gap_done = (int'(r_gap) + 2 >= GAP_CYC);

    always_ff @(posedge clk or posedge rst_async) begin
        if (rst_async)
            r_gap <= '0;
        else if (r_state != S_GAP)
            r_gap <= '0;
        else
            r_gap <= r_gap + 1'b1;
    end
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_pre_nxt   = r_pre;
        w_ms_nxt    = r_ms;
        w_flush     = 1'b0;
        w_take      = 1'b0;
        w_pop       = 1'b0;
        w_ld_note   = 1'b0;
        w_ld_sil    = 1'b0;
        w_done_nxt  = 1'b0;
        if (bus.stop) begin
            w_flush   = 1'b1;
            w_pre_nxt = '0;
            w_ms_nxt  = '0;
            if (r_state == S_IDLE && r_max_count == '0) begin
                w_state_nxt = S_IDLE;
            end else begin
                w_state_nxt = S_SILENCE;
                w_ld_sil    = 1'b1;
            end
        end else begin
            case (r_state)
                S_IDLE: w_take = !w_empty;
                S_LOAD: begin
                    if (r_dur == '0) begin
                        if (!w_empty) w_take = 1'b1;
                        else          w_state_nxt = S_IDLE;
                    end else begin
                        w_state_nxt = S_PLAY;
                        w_pre_nxt   = '0;
                        w_ms_nxt    = '0;
                    end
                end
                S_PLAY: begin
                    if (w_last) begin
                        w_pre_nxt = '0;
                        w_ms_nxt  = '0;
`ifdef SOUND_SEQ_GAP_EN
                        w_state_nxt = S_GAP;
                        if (r_max_count != '0) w_ld_sil = 1'b1;
`else
                        if (!w_empty) begin
                            w_take = 1'b1;
                        end else begin
                            w_state_nxt = S_SILENCE;
                            w_ld_sil    = 1'b1;
                        end
`endif
                    end else if (r_pre == PRE_LAST) begin
                        w_pre_nxt = '0;
                        w_ms_nxt  = r_ms + 16'd1;
                    end else begin
                        w_pre_nxt = r_pre + 1'b1;
                    end
                end
                S_SILENCE: w_state_nxt = S_IDLE;
`ifdef SOUND_SEQ_GAP_EN
                S_GAP: begin
                    if (w_gap_done) begin
                        if (!w_empty) w_take = 1'b1;
                        else          w_state_nxt = S_IDLE;
                    end
                end
`endif
                default: w_state_nxt = S_IDLE;
            endcase
        end
        if (w_take) begin
            w_state_nxt = S_LOAD;
            w_pop       = 1'b1;
            w_ld_note   = (w_head_dur != '0);
        end
        // note_done is registered, so it is raised on entry to the last PLAY cycle
        w_done_nxt = (w_state_nxt == S_PLAY) && (w_pre_nxt == PRE_LAST) &&
                     (w_ms_nxt == r_dur - 16'd1);
`ifdef SOUND_SEQ_GAP_EN
        if (!bus.stop && r_state == S_PLAY && w_done_nxt && r_max_count != '0)
            w_ld_sil = 1'b1;
`endif
    end

    assign w_count_nxt = r_count + CW'(w_push_ok) - CW'(w_pop);

    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem_per[r_wr_ptr] <= bus.note_period;
            r_mem_dur[r_wr_ptr] <= bus.note_duration_ms;
        end
    end

    always_ff @(posedge clk or posedge rst_async) begin
        if (rst_async) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_full     <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            r_overflow <= bus.note_push && r_full && !bus.stop;
            if (w_flush) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
                r_count  <= '0;
                r_full   <= 1'b0;
            end else begin
                if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
                if (w_pop)     r_rd_ptr <= r_rd_ptr + 1'b1;
                r_count <= w_count_nxt;
                r_full  <= (w_count_nxt == CW'(DEPTH));
            end
        end
    end

    always_ff @(posedge clk or posedge rst_async) begin
        if (rst_async) begin
            r_state     <= S_IDLE;
            r_pre       <= '0;
            r_ms        <= '0;
            r_dur       <= '0;
            r_max_count <= '0;
            r_latch     <= 1'b0;
            r_note_done <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_pre       <= w_pre_nxt;
            r_ms        <= w_ms_nxt;
            if (w_pop) r_dur <= w_head_dur;
            r_latch     <= w_ld_note | w_ld_sil;
            if (w_ld_note)     r_max_count <= w_head_per;
            else if (w_ld_sil) r_max_count <= '0;
            r_note_done <= w_done_nxt;
            r_busy      <= (w_state_nxt != S_IDLE);
        end
    end

    assign bus.fifo_full       = r_full;
    assign bus.fifo_count      = r_count;
    assign bus.overflow        = r_overflow;
    assign bus.busy            = r_busy;
    assign bus.note_done       = r_note_done;
    assign bus.max_count       = r_max_count;
    assign bus.latch_max_count = r_latch;
endmodule

// File: tb/tb_sound_sequencer.sv
// Bench for sound_sequencer: timeline model of the note schedule checked every
// cycle, plus literal latch/note_done timing expectations per scenario.
module tb_sound_sequencer;
    localparam int DEPTH  = 4;
    localparam int CPM    = 10;
    localparam int GAP_MS = 2;
    localparam int G      = GAP_MS * CPM;

    logic clk, rst;
    sound_sequencer_if #(.DEPTH(DEPTH)) bus ();

    sound_sequencer #(.DEPTH(DEPTH), .CLKS_PER_MS(CPM), .GAP_MS(GAP_MS)) dut (
        .clk       (clk),
        .rst_async (rst),
        .bus       (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input longint act, input longint exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Model: a note latched at cycle s with duration d is done at s+d*CPM and
    // hands over (next note or silence) at s+d*CPM+1.
    typedef struct {
        logic [25:0] per;
        logic [15:0] dur;
    } note_t;

    note_t       q[$];
    int          mode;      // 0 quiet, 1 note sounding, 2 silence cycle, 3 skipped note, 4 gap
    int          s, d, z, t;
    logic [25:0] e_max;
    bit          e_latch, e_done, e_ovf, e_busy, e_full;
    int          e_cnt;

    always @(posedge clk or posedge rst) begin
        int    sz0;
        bit    ld;
        note_t n;
        if (rst) begin
            q.delete();
            mode = 0; s = 0; d = 0; z = 0; t = 0;
            e_max = '0; e_latch = 0; e_done = 0; e_ovf = 0;
            e_busy = 0; e_full = 0; e_cnt = 0;
        end else begin
            t++;
            e_latch = 0; e_done = 0; e_ovf = 0; ld = 0;
            sz0 = q.size();
            if (bus.stop) begin
                q.delete();
                if (mode != 0 || e_max != 0) begin
                    mode = 2; e_latch = 1; e_max = '0;
                end
            end else begin
                case (mode)
                    0: ld = (sz0 > 0);
                    1: begin
                        if (t == s + d * CPM) begin
                            e_done = 1;
`ifdef SOUND_SEQ_GAP_EN
                            if (e_max != 0) begin e_latch = 1; e_max = '0; end
`endif
                        end else if (t == s + d * CPM + 1) begin
`ifdef SOUND_SEQ_GAP_EN
                            mode = 4; z = t - 1;
`else
                            if (sz0 > 0) ld = 1;
                            else begin mode = 2; e_latch = 1; e_max = '0; end
`endif
                        end
                    end
                    2: mode = 0;
                    3: if (sz0 > 0) ld = 1; else mode = 0;
                    4: if (t == z + G) begin
                        if (sz0 > 0) ld = 1; else mode = 0;
                    end
                    default: mode = 0;
                endcase
                if (ld) begin
                    n = q.pop_front();
                    if (n.dur == 0) mode = 3;
                    else begin
                        mode = 1; s = t; d = int'(n.dur);
                        e_latch = 1; e_max = n.per;
                    end
                end
                if (bus.note_push) begin
                    if (sz0 == DEPTH) e_ovf = 1;
                    else begin
                        n.per = bus.note_period; n.dur = bus.note_duration_ms;
                        q.push_back(n);
                    end
                end
            end
            e_busy = (mode != 0);
            e_cnt  = q.size();
            e_full = (q.size() == DEPTH);
        end
    end

    int          lat_t[$];
    logic [25:0] lat_v[$];
    int          done_t[$];
    int          n_ovf;

    always @(negedge clk) begin
        if (!rst) begin
            check("max_count", bus.max_count, e_max);
            check("latch_max_count", bus.latch_max_count, e_latch);
            check("note_done", bus.note_done, e_done);
            check("overflow", bus.overflow, e_ovf);
            check("busy", bus.busy, e_busy);
            check("fifo_count", bus.fifo_count, e_cnt);
            check("fifo_full", bus.fifo_full, e_full);
            if (bus.latch_max_count) begin
                lat_t.push_back(t);
                lat_v.push_back(bus.max_count);
            end
            if (bus.note_done) done_t.push_back(t);
            if (bus.overflow) n_ovf++;
        end
    end

    task automatic clear_logs();
        lat_t.delete(); lat_v.delete(); done_t.delete(); n_ovf = 0;
    endtask

    task automatic push_note(input int per, input int dur, output int k);
        bus.note_period      = 26'(per);
        bus.note_duration_ms = 16'(dur);
        bus.note_push        = 1'b1;
        @(posedge clk); #1;
        k = t;
        bus.note_push = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic wait_quiet(input string name, input int budget);
        int n = 0;
        while ((bus.busy || bus.fifo_count != 0) && n < budget) begin
            @(posedge clk); #1; n++;
        end
        total++;
        if (n >= budget) begin
            bad++;
            $display("FAIL %s: still busy after %0d cycles, expected quiet", name, n);
        end
        idle(3);
    endtask

    int k, kstop, n;
    int exp3[6] = '{5, 11, 12, 13, 14, 0};

    initial begin
        rst = 1'b1;
        bus.note_period = '0; bus.note_duration_ms = '0;
        bus.note_push = 1'b0; bus.stop = 1'b0;
        n_ovf = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst max_count", bus.max_count, 0);
        check("rst latch", bus.latch_max_count, 0);
        check("rst busy", bus.busy, 0);
        check("rst fifo_count", bus.fifo_count, 0);
        check("rst fifo_full", bus.fifo_full, 0);
        check("rst note_done", bus.note_done, 0);
        check("rst overflow", bus.overflow, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        idle(2);

`ifdef SOUND_SEQ_GAP_EN
        clear_logs();
        push_note(500, 1, k);
        push_note(600, 1, k);
        wait_quiet("gap quiet", 200);
        check("gap latch count", lat_v.size(), 4);
        check("gap v0", lat_v[0], 500);
        check("gap v1", lat_v[1], 0);
        check("gap v2", lat_v[2], 600);
        check("gap v3", lat_v[3], 0);
        check("gap zero after 500", lat_t[1] - lat_t[0], 10);
        check("gap 600 after zero", lat_t[2] - lat_t[1], 20);
        check("gap zero after 600", lat_t[3] - lat_t[2], 10);
        check("gap done count", done_t.size(), 2);
        check("gap done0", done_t[0] - lat_t[0], 10);
        idle(40);
        check("gap no end latch", lat_v.size(), 4);
`else
        // single note
        clear_logs();
        push_note(1000, 3, k);
        wait_quiet("t1 quiet", 200);
        check("t1 latch count", lat_v.size(), 2);
        check("t1 latency", lat_t[0] - k, 1);
        check("t1 v0", lat_v[0], 1000);
        check("t1 v1", lat_v[1], 0);
        check("t1 done count", done_t.size(), 1);
        check("t1 done delay", done_t[0] - lat_t[0], 30);
        check("t1 silence delay", lat_t[1] - lat_t[0], 31);

        // back-to-back notes
        clear_logs();
        push_note(500, 2, k);
        push_note(700, 1, k);
        push_note(900, 4, k);
        wait_quiet("t2 quiet", 300);
        check("t2 latch count", lat_v.size(), 4);
        check("t2 v0", lat_v[0], 500);
        check("t2 v1", lat_v[1], 700);
        check("t2 v2", lat_v[2], 900);
        check("t2 v3", lat_v[3], 0);
        check("t2 gap01", lat_t[1] - lat_t[0], 21);
        check("t2 gap12", lat_t[2] - lat_t[1], 11);
        check("t2 gap23", lat_t[3] - lat_t[2], 41);

        // overflow while a long note plays
        clear_logs();
        push_note(5, 100, k);
        idle(3);
        push_note(11, 1, k);
        push_note(12, 1, k);
        push_note(13, 1, k);
        push_note(14, 1, k);
        push_note(99, 1, k);
        idle(2);
        check("t3 fifo_full", bus.fifo_full, 1);
        check("t3 fifo_count", bus.fifo_count, 4);
        check("t3 overflow pulses", n_ovf, 1);
        wait_quiet("t3 quiet", 1500);
        check("t3 latch count", lat_v.size(), 6);
        for (int i = 0; i < 6; i++) check("t3 latch value", lat_v[i], exp3[i]);

        // zero-duration note is skipped
        clear_logs();
        push_note(77, 0, k);
        push_note(800, 1, k);
        wait_quiet("t4 quiet", 100);
        check("t4 latch count", lat_v.size(), 2);
        check("t4 v0", lat_v[0], 800);
        check("t4 v1", lat_v[1], 0);

        // stop mid-note with entries queued
        clear_logs();
        push_note(333, 5, k);
        push_note(444, 1, k);
        push_note(555, 1, k);
        n = 0;
        while (lat_t.size() == 0 && n < 20) begin @(posedge clk); #1; n++; end
        check("t5 first latch seen", lat_t.size(), 1);
        idle(3);
        bus.stop = 1'b1;
        @(posedge clk); #1;
        kstop = t;
        bus.stop = 1'b0;
        check("t5 fifo_count", bus.fifo_count, 0);
        idle(30);
        check("t5 latch count", lat_v.size(), 2);
        check("t5 v0", lat_v[0], 333);
        check("t5 v1", lat_v[1], 0);
        check("t5 stop latch cycle", lat_t[1], kstop);
        check("t5 no note_done", done_t.size(), 0);
        check("t5 busy", bus.busy, 0);

        // stop with a same-cycle push while quiet
        clear_logs();
        bus.note_period = 26'd123; bus.note_duration_ms = 16'd1;
        bus.note_push = 1'b1; bus.stop = 1'b1;
        @(posedge clk); #1;
        bus.note_push = 1'b0; bus.stop = 1'b0;
        idle(10);
        check("t6 no latch", lat_v.size(), 0);
        check("t6 no overflow", n_ovf, 0);
        check("t6 fifo_count", bus.fifo_count, 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
